// File: rtl/bc_if.sv
// bc_if: control bundle between the polynomial requester and the bc controller
// iniciar  requester -> bc  level start request
// M0/M1/M2 bc -> datapath   operand / ALU port A / ALU port B selects
// load_*   bc -> datapath   x, H and L register loads
// h        bc -> datapath   ALU op (0 add, 1 multiply)
// pronto   bc -> requester  result valid
// ocupado  bc -> requester  run in progress
interface bc_if;
    logic       iniciar;
    logic [1:0] M0, M1, M2;
    logic       load_x, load_h, load_l, h, pronto, ocupado;
    modport master (output iniciar, input M0, M1, M2, load_x, load_h, load_l, h, pronto, ocupado);
    modport slave  (input iniciar, output M0, M1, M2, load_x, load_h, load_l, h, pronto, ocupado);
endinterface

// File: rtl/bc.sv
// bc: Moore controller sequencing a·x² + b·x + c through a Horner datapath
// clock  rising-edge system clock
// reset  asynchronous active-high reset, returns to OCIOSO with all outputs 0
// bus    bc_if.slave: iniciar in; M0/M1/M2, load_x/h/l, h, pronto, ocupado out
module bc (
    input  logic clock,
    input  logic reset,
    bc_if.slave  bus
);
    typedef enum logic [2:0] {OCIOSO, CARREGA_X, MUL1, SOMA1, MUL2, SOMA2, FIM} state_e;
    logic [2:0] state, nxt;
    always_comb begin
        case (state)
            OCIOSO:    nxt = bus.iniciar ? CARREGA_X : OCIOSO;
            CARREGA_X: nxt = MUL1;
            MUL1:      nxt = SOMA1;
            SOMA1:     nxt = MUL2;
            MUL2:      nxt = SOMA2;
            SOMA2:     nxt = FIM;
            FIM:       nxt = bus.iniciar ? FIM : OCIOSO;
            default:   nxt = OCIOSO;
        endcase
    end
    // outputs are decoded from the next state so they are registered yet still match the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= OCIOSO;
            bus.M0      <= 2'b00;
            bus.M1      <= 2'b00;
            bus.M2      <= 2'b00;
            bus.h       <= 1'b0;
            bus.load_x  <= 1'b0;
            bus.load_h  <= 1'b0;
            bus.load_l  <= 1'b0;
            bus.pronto  <= 1'b0;
            bus.ocupado <= 1'b0;
        end else begin
            state       <= nxt;
            bus.M0      <= nxt == MUL1 ? 2'b01 : nxt == SOMA1 ? 2'b10 : nxt == SOMA2 ? 2'b11 : 2'b00;
            bus.M1      <= nxt == MUL1 ? 2'b01 : (nxt == SOMA1 || nxt == MUL2 || nxt == SOMA2) ? 2'b11 : 2'b00;
            bus.M2      <= (nxt == MUL1 || nxt == MUL2) ? 2'b01 : 2'b00;
            bus.h       <= nxt == MUL1 || nxt == MUL2;
            bus.load_x  <= nxt == CARREGA_X;
            bus.load_h  <= nxt == MUL1 || nxt == SOMA1 || nxt == MUL2;
            bus.load_l  <= nxt == SOMA2;
            bus.pronto  <= nxt == FIM;
            bus.ocupado <= !(nxt == OCIOSO || nxt == FIM);
        end
    end
endmodule

// File: tb/tb_bc.sv
// tb_bc: randomized self-checking bench for bc with a behavioural Horner datapath
module tb_bc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] valor_x = '0, a = '0, b = '0, c = '0;
    logic [15:0] rx, rh, rl, opm0, opa, opb, alu, saida;
    logic [31:0] prod;
    int tests = 0, fails = 0;

    bc_if bus ();
    bc dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // datapath as described by the select encodings
    assign saida = bus.pronto ? rl : 16'd0;
    assign opm0  = bus.M0 == 2'd0 ? 16'd0 : bus.M0 == 2'd1 ? a : bus.M0 == 2'd2 ? b : c;
    assign opa   = bus.M1 == 2'd0 ? rx : bus.M1 == 2'd1 ? opm0 : bus.M1 == 2'd2 ? saida : rh;
    assign opb   = bus.M2 == 2'd0 ? opm0 : bus.M2 == 2'd1 ? rx : bus.M2 == 2'd2 ? saida : rh;
    assign prod  = opa * opb;
    assign alu   = bus.h ? prod[15:0] : opa + opb;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rx <= '0;
            rh <= '0;
            rl <= '0;
        end else begin
            if (bus.load_x) rx <= valor_x;
            if (bus.load_h) rh <= alu;
            if (bus.load_l) rl <= alu;
        end
    end

    // {M0,M1,M2,h,load_x,load_h,load_l,pronto,ocupado}
    localparam logic [11:0] V_CX   = 12'b00_00_00_0_1_0_0_0_1;
    localparam logic [11:0] V_MUL1 = 12'b01_01_01_1_0_1_0_0_1;
    localparam logic [11:0] V_SOM1 = 12'b10_11_00_0_0_1_0_0_1;
    localparam logic [11:0] V_MUL2 = 12'b00_11_01_1_0_1_0_0_1;
    localparam logic [11:0] V_SOM2 = 12'b11_11_00_0_0_0_1_0_1;
    localparam logic [11:0] V_FIM  = 12'b00_00_00_0_0_0_0_1_0;

    function automatic logic [11:0] outs();
        return {bus.M0, bus.M1, bus.M2, bus.h, bus.load_x, bus.load_h, bus.load_l, bus.pronto, bus.ocupado};
    endfunction

    function automatic logic [15:0] poly(input logic [15:0] px, pa, pb, pc);
        longint r;
        r = longint'(pa) * longint'(px) * longint'(px) + longint'(pb) * longint'(px) + longint'(pc);
        return r[15:0];
    endfunction

    task automatic do_run(input logic [15:0] vx, va, vb, vc, output int cyc, output logic [15:0] res);
        valor_x = vx; a = va; b = vb; c = vc;
        @(negedge clock);
        bus.iniciar = 1'b1;
        cyc = 0;
        while (!bus.pronto && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        res = saida;
        bus.iniciar = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.iniciar = 1'b0;
        @(negedge clock);
        tests++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b want=%b", outs(), 12'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [11:0] seq [6] = '{V_CX, V_MUL1, V_SOM1, V_MUL2, V_SOM2, V_FIM};
        valor_x = 16'd2; a = 16'd3; b = 16'd4; c = 16'd5;
        @(negedge clock);
        bus.iniciar = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            tests++;
            if (outs() !== seq[i]) begin
                fails++;
                $display("FAIL basic_step%0d got=%b want=%b", i, outs(), seq[i]);
            end
        end
        tests++;
        if (saida !== 16'd25) begin
            fails++;
            $display("FAIL basic_result got=%0d want=25", saida);
        end
        bus.iniciar = 1'b0;
        @(negedge clock);
        tests++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL basic_return_idle got=%b want=%b", outs(), 12'd0);
        end
    endtask

    task automatic test_values();
        logic [15:0] vec [3][5] = '{'{16'd0, 16'd7, 16'd9, 16'd11, 16'd11},
                                    '{16'd255, 16'd2, 16'd0, 16'd0, 16'd64514},
                                    '{16'd255, 16'd1, 16'd0, 16'd0, 16'd65025}};
        int cyc;
        logic [15:0] res;
        for (int i = 0; i < 3; i++) begin
            do_run(vec[i][0], vec[i][1], vec[i][2], vec[i][3], cyc, res);
            tests++;
            if (res !== vec[i][4] || cyc != 6) begin
                fails++;
                $display("FAIL directed%0d got=%0d/%0dcyc want=%0d/6cyc", i, res, cyc, vec[i][4]);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        logic [15:0] res, vx, va, vb, vc;
        for (int i = 0; i < 10; i++) begin
            vx = 16'($urandom); va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
            do_run(vx, va, vb, vc, cyc, res);
            tests++;
            if (res !== poly(vx, va, vb, vc) || cyc != 6) begin
                fails++;
                $display("FAIL random%0d x=%0d a=%0d b=%0d c=%0d got=%0d/%0dcyc want=%0d/6cyc",
                         i, vx, va, vb, vc, res, cyc, poly(vx, va, vb, vc));
            end
        end
    endtask

    task automatic test_reset_mid();
        int pr = 0, cyc;
        logic [15:0] res;
        valor_x = 16'd2; a = 16'd3; b = 16'd4; c = 16'd5;
        @(negedge clock);
        bus.iniciar = 1'b1;
        repeat (4) @(negedge clock);
        tests++;
        if (outs() !== V_MUL2) begin
            fails++;
            $display("FAIL resetmid_in_mul2 got=%b want=%b", outs(), V_MUL2);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL resetmid_async got=%b want=%b", outs(), 12'd0);
        end
        bus.iniciar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pr += int'(bus.pronto) + int'(bus.ocupado);
        end
        tests++;
        if (pr != 0) begin
            fails++;
            $display("FAIL resetmid_stays_idle got=%0d want=0", pr);
        end
        do_run(16'd2, 16'd3, 16'd4, 16'd5, cyc, res);
        tests++;
        if (res !== 16'd25 || cyc != 6) begin
            fails++;
            $display("FAIL resetmid_rerun got=%0d/%0dcyc want=25/6cyc", res, cyc);
        end
    endtask

    task automatic test_handshake();
        int lx = 0, pr_early = 0, pr_late = 0, oc = 0;
        valor_x = 16'd3; a = 16'd1; b = 16'd1; c = 16'd1;
        @(negedge clock);
        bus.iniciar = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            lx += int'(bus.load_x);
            if (i < 6) pr_early += int'(bus.pronto);
            else pr_late += int'(bus.pronto);
        end
        tests++;
        if (lx != 1 || pr_early != 0 || pr_late != 15) begin
            fails++;
            $display("FAIL hold_single_run got=lx%0d/early%0d/late%0d want=lx1/early0/late15", lx, pr_early, pr_late);
        end
        tests++;
        if (saida !== 16'd13) begin
            fails++;
            $display("FAIL hold_result got=%0d want=13", saida);
        end
        bus.iniciar = 1'b0;
        @(negedge clock);
        tests++;
        if (bus.pronto !== 1'b0) begin
            fails++;
            $display("FAIL drop_pronto got=%b want=0", bus.pronto);
        end
        bus.iniciar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            oc += int'(bus.ocupado);
        end
        tests++;
        if (oc != 5 || bus.pronto !== 1'b1) begin
            fails++;
            $display("FAIL second_run got=ocupado%0d/pronto%b want=ocupado5/pronto1", oc, bus.pronto);
        end
        bus.iniciar = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_illegal();
        bus.iniciar = 1'b0;
        @(negedge clock);
        force dut.state = 3'b111;
        #1 release dut.state;
        @(negedge clock);
        tests++;
        if (outs() !== 12'd0) begin
            fails++;
            $display("FAIL illegal_recover got=%b want=%b", outs(), 12'd0);
        end
        bus.iniciar = 1'b1;
        @(negedge clock);
        tests++;
        if (outs() !== V_CX) begin
            fails++;
            $display("FAIL illegal_then_start got=%b want=%b", outs(), V_CX);
        end
        bus.iniciar = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_random();
        test_reset_mid();
        test_handshake();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bc.md
# bc

Control block (FSM) for the polynomial datapath that computes resultado = a·x² + b·x + c with Horner's rule, ((a·x)+b)·x + c. It drives the datapath mux selects (M0, M1, M2), register loads (load_x, load_l, load_h), the ALU operation select (h) and the output enable (pronto). It accepts a level start request and reports completion back to the requester.

## Interface
- No parameters.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces OCIOSO immediately.
- iniciar  input  1  start request, level-sensitive; sampled only in OCIOSO and FIM.
- M0  output  2  datapath operand select: 00=zero, 01=a, 10=b, 11=c.
- M1  output  2  ALU port A select: 00=x, 01=M0 value, 10=saida, 11=reg_h.
- M2  output  2  ALU port B select: 00=M0 value, 01=x, 10=saida, 11=reg_h.
- load_x  output  1  load the x register.
- load_h  output  1  load the H register from the ALU.
- load_l  output  1  load the L register from the ALU.
- h  output  1  ALU op: 0 = add (A+B), 1 = multiply (low 16 bits of A·B).
- pronto  output  1  result valid; gates reg_l onto the datapath output.
- ocupado  output  1  high in every state except OCIOSO and FIM.

## Operation
- Moore FSM. All outputs decode from the state only. Outputs not listed for a state are 0.
- OCIOSO: M0=M1=M2=00, h=0.
  - iniciar=1 → CARREGA_X.
  - iniciar=0 → stay.
- CARREGA_X: load_x=1 → MUL1.
- MUL1: M0=01, M1=01, M2=01, h=1, load_h=1. H ← a·x. → SOMA1.
- SOMA1: M0=10, M1=11, M2=00, h=0, load_h=1. H ← H+b. → MUL2.
- MUL2: M1=11, M2=01, h=1, load_h=1. H ← H·x. → SOMA2.
- SOMA2: M0=11, M1=11, M2=00, h=0, load_h=0, load_l=1. L ← H+c. → FIM.
- FIM: pronto=1, and all other outputs are at the OCIOSO values.
  - iniciar=1 → stay, holding the result.
  - iniciar=0 → OCIOSO.
- ocupado=1 in CARREGA_X, MUL1, SOMA1, MUL2 and SOMA2.
- Arithmetic is modulo 2¹⁶ (the datapath truncates). The block does not detect overflow.
- Unused state encodings → OCIOSO on the next edge, with default outputs while there.
- At most one of load_x, load_h, load_l is high in any cycle.

## Timing
- Reset: state=OCIOSO and every output 0, applied asynchronously. The datapath registers clear on the same reset.
- Reset asserted mid-operation aborts immediately. pronto stays 0 until a new run completes.
- Latency: iniciar sampled high in OCIOSO at edge 0 → CARREGA_X after edge 0 → pronto=1 after edge 5. Six cycles from request to result.
- valor_x must be stable during CARREGA_X. a, b, c must be stable from MUL1 through SOMA2.
- Handshake: the requester holds iniciar until pronto=1, then drops it. pronto falls one cycle after iniciar is sampled low in FIM.
- A new run needs iniciar low for at least one edge (FIM → OCIOSO) before it is raised again. Holding iniciar high never retriggers.
- iniciar changes during CARREGA_X through SOMA2 are ignored.

## Test plan
- Basic run: x=2, a=3, b=4, c=5, iniciar pulse held until pronto.
  - Required: state sequence CARREGA_X, MUL1, SOMA1, MUL2, SOMA2, FIM, with the exact per-state M0/M1/M2/h/load values above.
  - Required: pronto after 6 cycles, resultado=25.
- Zero x: x=0, a=7, b=9, c=11 → resultado=11.
- Wrap-around: x=255, a=2, b=0, c=0 → resultado=64514 (130050 mod 65536).
  - Same with a=1 → 65025.
- Reset mid-operation: assert reset asynchronously during MUL2.
  - Required: all outputs 0 immediately, state OCIOSO, pronto stays 0.
  - Required: a later run with x=2, a=3, b=4, c=5 still returns 25.
- Handshake:
  - Hold iniciar high for 20 cycles → exactly one run; pronto stays 1 from cycle 6 onward.
  - Drop iniciar → pronto=0 next cycle.
  - Raise iniciar again → a second run starts, and ocupado=1 for exactly 5 cycles.
- Illegal state (forced by the bench) → OCIOSO on the next edge, no load asserted.
